mem_io_responder: RTL

- Memory-side responder for the byte-serial memory interface driven by the CPU memory controller.
- Holds the unified byte-addressed RAM and returns read data one cycle after the address is sampled.
- Decodes the IO window, buffers IO output bytes in a TX FIFO and input bytes in an RX FIFO.
- Generates io_buffer_full back to the initiator and a sticky program_finish flag.

---
 rtl/mem_io_responder_if.sv | 19 +
 rtl/mem_io_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus between the CPU memory controller (master) and the
// memory/IO responder (slave).
interface mem_io_responder_if;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;

  modport master (
    output mem_addr, mem_wr, mem_din,
    input  mem_dout, io_buffer_full
  );

  modport slave (
    input  mem_addr, mem_wr, mem_din,
    output mem_dout, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: unified byte RAM with 1-cycle read latency, an IO
// window with TX/RX byte FIFOs, io_buffer_full back-pressure and sticky flags.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_WID = 17,
  parameter int unsigned TX_DEPTH     = 8,
  parameter int unsigned RX_DEPTH     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  mem_io_responder_if.slave   bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                program_finish,
  output logic                io_err
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WID;
  localparam int unsigned TX_PW     = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW     = TX_PW + 1;
  localparam int unsigned RX_PW     = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW     = RX_PW + 1;

  logic [7:0] ram    [RAM_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count, tx_count_nxt;
  logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count, rx_count_nxt;

  logic                    is_io;
  logic [2:0]              off;
  logic [RAM_ADDR_WID-1:0] ram_idx;
  logic                    unused_addr_hi;

  logic tx_full, rx_full, rx_nonempty;
  logic tx_wr_req, tx_push, tx_pop, tx_ovf;
  logic rx_rd_req, rx_push, rx_pop, rx_ovf;
  logic ram_we, fin_wr;
  logic [7:0] rd_byte;

  // Address decode; upper address bits are don't-care.
  assign is_io          = (bus.mem_addr[17:16] == 2'b11);
  assign off            = bus.mem_addr[2:0];
  assign ram_idx        = bus.mem_addr[RAM_ADDR_WID-1:0];
  assign unused_addr_hi = ^bus.mem_addr[31:18];

  assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
  assign rx_full     = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_nonempty = (rx_count != '0);
  assign tx_valid    = (tx_count != '0);
  assign tx_data     = tx_mem[tx_rd_ptr];

  // Push/pop qualification; a simultaneous pop frees room for a push into a full FIFO.
  always_comb begin
    tx_pop    = rdy & tx_valid & tx_ready;
    tx_wr_req = rdy & is_io & bus.mem_wr & (off == 3'd0);
    tx_push   = tx_wr_req & (~tx_full | tx_pop);
    tx_ovf    = tx_wr_req & tx_full & ~tx_pop;

    rx_rd_req = rdy & is_io & ~bus.mem_wr & (off == 3'd0);
    rx_pop    = rx_rd_req & rx_nonempty;
    rx_push   = rdy & rx_valid & (~rx_full | rx_pop);
    rx_ovf    = rdy & rx_valid & rx_full & ~rx_pop;

    ram_we    = rdy & ~is_io & bus.mem_wr;
    fin_wr    = rdy & is_io & bus.mem_wr & (off == 3'd4);

    tx_count_nxt = tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
    rx_count_nxt = rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
  end

  // Read data mux: RAM byte, RX head, or IO status.
  always_comb begin
    rd_byte = 8'h00;
    if (is_io) begin
      case (off)
        3'd0:    rd_byte = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
        3'd4:    rd_byte = {6'b0, rx_nonempty, tx_full};
        default: rd_byte = 8'h00;
      endcase
    end else begin
      rd_byte = ram[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_dout       <= 8'h00;
      bus.io_buffer_full <= 1'b0;
      tx_wr_ptr          <= '0;
      tx_rd_ptr          <= '0;
      tx_count           <= '0;
      rx_wr_ptr          <= '0;
      rx_rd_ptr          <= '0;
      rx_count           <= '0;
      program_finish     <= 1'b0;
      io_err             <= 1'b0;
    end else if (rdy) begin
      if (!bus.mem_wr) bus.mem_dout <= rd_byte;
      if (tx_push) tx_wr_ptr <= TX_PW'(tx_wr_ptr + TX_PW'(1));
      if (tx_pop)  tx_rd_ptr <= TX_PW'(tx_rd_ptr + TX_PW'(1));
      if (rx_push) rx_wr_ptr <= RX_PW'(rx_wr_ptr + RX_PW'(1));
      if (rx_pop)  rx_rd_ptr <= RX_PW'(rx_rd_ptr + RX_PW'(1));
      tx_count <= tx_count_nxt;
      rx_count <= rx_count_nxt;
      // Two-entry margin absorbs the initiator's sampling delay plus one in-flight write.
      bus.io_buffer_full <= (tx_count_nxt >= TX_CW'(TX_DEPTH - 2));
      if (tx_ovf | rx_ovf) io_err <= 1'b1;
      if (fin_wr) program_finish <= 1'b1;
    end
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && ram_we)  ram[ram_idx]       <= bus.mem_din;
    if (!rst && tx_push) tx_mem[tx_wr_ptr]  <= bus.mem_din;
    if (!rst && rx_push) rx_mem[rx_wr_ptr]  <= rx_data;
  end

endmodule
